// File: rtl/result_read_sequencer_if.sv
// Output stream bundle of the result read sequencer.
// The sequencer drives word/valid; downstream drives ready.
interface result_read_sequencer_if #(
  parameter int DW = 16
);
  logic [DW-1:0] DataOut;
  logic          Valid;
  logic          Ready;

  modport master (
    output DataOut,
    output Valid,
    input  Ready
  );

  modport slave (
    input  DataOut,
    input  Valid,
    output Ready
  );
endinterface

// File: rtl/result_read_sequencer.sv
// Walks the result register file in write order and streams
// each committed entry downstream over valid/ready.
module result_read_sequencer #(
  parameter int DEPTH = 15,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          Start,
  input  logic          WrEn,
  output logic [AW-1:0] ReadReg,
  input  logic [DW-1:0] ReadData,
  output logic          Done,
  output logic          Err,
  result_read_sequencer_if.master out_if
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_e;

  state_e           state_q;
  logic [DEPTH-1:0] ptr_q;
  logic [CW-1:0]    wcnt_q;
  logic [CW-1:0]    rcnt_q;
  logic [DW-1:0]    data_q;
  logic             valid_q;
  logic             done_q;
  logic             err_q;

  logic fetch;
  logic accept;

  assign accept = valid_q && out_if.Ready;
  // Strict rcnt < wcnt: an entry is only readable the cycle after its write.
  assign fetch  = (state_q == RUN) && (rcnt_q < wcnt_q)
                  && (!valid_q || out_if.Ready);

  always_comb begin
    ReadReg = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ptr_q[i]) ReadReg = ReadReg | AW'(i);
    end
  end

  assign out_if.DataOut = data_q;
  assign out_if.Valid   = valid_q;
  assign Done           = done_q;
  assign Err            = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= DEPTH'(1);
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (Start) begin
        state_q <= RUN;
        ptr_q   <= DEPTH'(1);
        wcnt_q  <= CW'(WrEn);
        rcnt_q  <= '0;
        valid_q <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        if (state_q != IDLE && WrEn) begin
          if (wcnt_q == FULL) err_q <= 1'b1;
          else wcnt_q <= wcnt_q + CW'(1);
        end
        unique case (state_q)
          IDLE: state_q <= IDLE;
          RUN: begin
            if (fetch) begin
              data_q  <= ReadData;
              valid_q <= 1'b1;
              ptr_q   <= {ptr_q[DEPTH-2:0], ptr_q[DEPTH-1]};
              rcnt_q  <= rcnt_q + CW'(1);
              if (rcnt_q == LAST) state_q <= FLUSH;
            end else if (accept) begin
              valid_q <= 1'b0;
            end
          end
          FLUSH: begin
            if (accept) begin
              done_q  <= 1'b1;
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/result_read_sequencer.md
# result_read_sequencer

Read-side companion to the write address counter in the CNN single-layer datapath. Once the multiplier results for a frame start landing in the register file, this block walks the register file's read port through entries 0..DEPTH-1 in write order. It never reads an entry before that entry has been written, and it streams each word to the downstream stage over a valid/ready handshake. It pulses `Done` when the last entry of the frame has been consumed.

## Interface
- `DEPTH`, 15: entries per frame; matches the 15-stage write ring.
- `AW`, 4: register-file address width.
- `DW`, 16: data word width.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Start`  in  1  one-cycle pulse that begins a new frame.
- `WrEn`  in  1  the write side commits one entry this cycle. Entries are committed in order 0..DEPTH-1.
- `ReadReg`  out  AW  register-file read address. It is the binary encoding of the internal one-hot read pointer.
- `ReadData`  in  DW  combinational register-file read data for `ReadReg`.
- `DataOut`  out  DW  registered output word.
- `Valid`  out  1  `DataOut` holds a word.
- `Ready`  in  1  downstream accepts the word when `Valid && Ready`.
- `Done`  out  1  one-cycle pulse when the last entry is accepted.
- `Err`  out  1  sticky flag: a write was attempted on a full frame. Cleared only by `Start` or reset.

## Operation
- **Read pointer:** DEPTH-bit one-hot ring, reset to bit 0. A one-hot-to-binary encoder drives `ReadReg` with index 0..DEPTH-1.
- **Write count:** `wcnt`, range 0..DEPTH, tracks committed entries.
- **Read count:** `rcnt`, range 0..DEPTH, tracks fetched entries.
- **States:**
  - IDLE: `WrEn` is ignored; the block waits for `Start`.
  - RUN: fetches and streams entries.
  - FLUSH: the last entry has been fetched; waiting for its acceptance.
- **IDLE -> RUN on `Start`:**
  - Clear `wcnt`, `rcnt`, the one-hot pointer (to bit 0), `Valid` and `Err`.
  - A `WrEn` in the same cycle as `Start` counts as entry 0, so `wcnt` becomes 1.
- **Fetch condition in RUN:** `rcnt < wcnt` and the output slot is free (`!Valid || Ready`).
- **On fetch:**
  - `DataOut <= ReadData` and `Valid <= 1`.
  - Rotate the one-hot pointer left.
  - `rcnt <= rcnt + 1`.
- **Leaving RUN:** when `rcnt` reaches DEPTH, the pointer wraps to bit 0 and the state goes to FLUSH.
- **Acceptance without a fetch:** `Valid && Ready` with no fetch that cycle gives `Valid <= 0`.
- **FLUSH:** on `Valid && Ready`, pulse `Done`, drop `Valid` and return to IDLE.
- **Full frame:** `WrEn` while `wcnt == DEPTH` is ignored and sets `Err`.
- **`Start` during RUN or FLUSH:** aborts the frame.
  - Any pending word is dropped.
  - There is no `Done` pulse.
  - The block re-enters RUN with cleared counters.
- **`Start` while `Done` would fire:** `Start` has priority and `Done` is suppressed.
- **Holding under backpressure:** `DataOut` is stable while `Valid && !Ready`.
- **Width rules:** `wcnt` and `rcnt` are `clog2(DEPTH+1)` bits wide. Counts never exceed DEPTH.

## Timing
- **Reset values:**
  - `ReadReg` = 0.
  - `DataOut` = 0.
  - `Valid` = 0.
  - `Done` = 0.
  - `Err` = 0.
  - State = IDLE.
- **Write-to-output latency:** if `WrEn` is asserted in cycle n, that entry is fetched no earlier than cycle n+1 and `Valid` rises in cycle n+2. There is no write-to-read bypass.
- **Fetch timing:** `ReadReg` presents the address during the fetch cycle; `ReadData` is sampled at the closing edge.
- **Throughput:** one word per cycle when `Ready` is held high and writes stay ahead.
- **`Done`:** high for exactly the cycle after the final acceptance edge.
- **Reset mid-frame:** everything returns to reset values immediately, without waiting for a clock.

## Test plan
- **Back-to-back frame:**
  - Stimulus: `Start` with `WrEn` in the same cycle, then `WrEn` for 14 more cycles. Register file holds entry i = 16'h0100+i. `Ready`=1.
  - Response: `ReadReg` steps 0..14. `DataOut` = 0100..010E on 15 consecutive `Valid` cycles, starting 2 cycles after the first `WrEn`. `Done` pulses once after 010E is accepted.
- **Read never passes write:**
  - Stimulus: `WrEn` only every 3rd cycle.
  - Response: `Valid` never exceeds the count of written entries; `ReadReg` stalls at the next unwritten index.
- **Backpressure:**
  - Stimulus: `Ready`=0 for 5 cycles while entry 3 is presented.
  - Response: `DataOut` and `ReadReg` are stable; nothing is lost or duplicated after `Ready` returns.
- **Overflow:**
  - Stimulus: 16 `WrEn` pulses in one frame.
  - Response: `Err`=1 from the 16th pulse; 15 words are streamed. The next `Start` clears `Err`.
- **Abort:**
  - Stimulus: `Start` pulsed after 7 words.
  - Response: `Valid` drops, there is no `Done`, and `ReadReg` returns to 0. The new frame streams from entry 0.
- **Async reset:**
  - Stimulus: `rst_n` dropped mid-cycle during streaming.
  - Response: all outputs are 0 at once, before the next edge, and the state is IDLE.
